// File: rtl/bcd_display_driver_pkg.sv
// Shared constants for the BCD display driver: segment patterns, FSM encoding and
// accumulator sizing.
package bcd_display_driver_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StCommit
  } state_e;

  // Patterns are {g,f,e,d,c,b,a}, active high.
  localparam logic [6:0] SegDigits [10] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
  };
  localparam logic [6:0] SegDash  = 7'b1000000;
  localparam logic [6:0] SegBlank = 7'b0000000;

  // ceil(width * log10(2)); width*log10(2) is never an integer for width >= 1.
  function automatic int unsigned calc_nacc(input int unsigned width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_display_driver_seven_segment.sv
// Decimal digit to 7-segment pattern; codes above 9 decode to blank.
module seven_segment
  import bcd_display_driver_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SegBlank;
    if (bcd < 4'd10) seg = SegDigits[bcd];
  end

endmodule

// File: rtl/bcd_display_driver.sv
// Binary to BCD conversion (double-dabble, one bit per cycle) feeding a multiplexed
// 7-segment display with leading-zero blanking and overflow dash.
module bcd_display_driver
  import bcd_display_driver_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DIGITS   = 3,
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned BLANK_LZ = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  value,
  input  logic              load,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] digit_en
);

  localparam int unsigned NACC = calc_nacc(WIDTH);
  localparam int unsigned EXT  = (NACC > DIGITS) ? NACC : DIGITS;
  localparam int unsigned CW   = $clog2(WIDTH + 1);
  localparam int unsigned SW   = $clog2(SCAN_DIV);
  localparam int unsigned IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_e              state_q;
  logic [WIDTH-1:0]    bin_q;
  logic [4*NACC-1:0]   acc_q, acc_adj;
  logic [4*EXT-1:0]    acc_ext;
  logic [CW-1:0]       cnt_q;
  logic [4*DIGITS-1:0] disp_q;
  logic                overflow_q, done_q, acc_ovf;

  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < NACC; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    acc_ext = '0;
    acc_ext[4*NACC-1:0] = acc_q;
    acc_ovf = |(acc_ext >> (4 * DIGITS));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      bin_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      disp_q     <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (load) begin
            bin_q   <= value;
            acc_q   <= '0;
            cnt_q   <= CW'(WIDTH);
            state_q <= StShift;
          end
        end
        StShift: begin
          {acc_q, bin_q} <= {acc_adj, bin_q} << 1;
          cnt_q          <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= StCommit;
        end
        StCommit: begin
          disp_q     <= acc_ext[4*DIGITS-1:0];
          overflow_q <= acc_ovf;
          done_q     <= 1'b1;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign overflow = overflow_q;

  logic [SW-1:0]     scan_q;
  logic [IW-1:0]     idx_q, idx_d;
  logic [3:0]        nib_sel;
  logic [DIGITS-1:0] lz, en_d, en_q;
  logic              run, blank_sel;
  logic [6:0]        seg_dec, seg_d, seg_q;

  // Everything below is decoded for the slot about to be shown (idx_d).
  always_comb begin
    idx_d     = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    lz        = '0;
    run       = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      run   = run & (disp_q[4*i +: 4] == 4'd0);
      lz[i] = run;
    end
    nib_sel   = '0;
    blank_sel = 1'b0;
    en_d      = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_d == IW'(i)) begin
        nib_sel   = disp_q[4*i +: 4];
        blank_sel = lz[i];
        en_d[i]   = 1'b1;
      end
    end
    if (overflow_q) seg_d = SegDash;
    else if ((BLANK_LZ != 0) && blank_sel) seg_d = SegBlank;
    else seg_d = seg_dec;
  end

  seven_segment u_seven_segment (
    .bcd (nib_sel),
    .seg (seg_dec)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_q <= '0;
      idx_q  <= '0;
      en_q   <= DIGITS'(1);
      seg_q  <= SegDigits[0];
    end else if (scan_q == SW'(SCAN_DIV - 1)) begin
      scan_q <= '0;
      idx_q  <= idx_d;
      en_q   <= en_d;
      seg_q  <= seg_d;
    end else begin
      scan_q <= scan_q + SW'(1);
    end
  end

  assign seg      = seg_q;
  assign digit_en = en_q;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Directed bench for bcd_display_driver: three instances with different sizes share
// clock and reset; display contents are observed through the scanned seg/digit_en.
module tb_bcd_display_driver;

  localparam logic [6:0] S0 = 7'b0111111, S1 = 7'b0000110, S2 = 7'b1011011;
  localparam logic [6:0] S3 = 7'b1001111, S4 = 7'b1100110, S5 = 7'b1101101;
  localparam logic [6:0] S6 = 7'b1111101, S7 = 7'b0000111, SD = 7'b1000000;
  localparam logic [6:0] SB = 7'b0000000;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  val0, val1;
  logic [15:0] val2;
  logic        ld0, ld1, ld2;
  logic        busy0, busy1, busy2, done0, done1, done2, ovf0, ovf1, ovf2;
  logic [6:0]  seg0, seg1, seg2;
  logic [2:0]  en0;
  logic [1:0]  en1;
  logic [4:0]  en2;

  int pass_cnt = 0;
  int total    = 0;
  int cyc;
  int ndone;

  always #5 clk = ~clk;

  bcd_display_driver #(.WIDTH(8), .DIGITS(3), .SCAN_DIV(4), .BLANK_LZ(1)) dut0 (
    .clk(clk), .reset(reset), .value(val0), .load(ld0), .busy(busy0), .done(done0),
    .overflow(ovf0), .seg(seg0), .digit_en(en0)
  );
  bcd_display_driver #(.WIDTH(8), .DIGITS(2), .SCAN_DIV(4), .BLANK_LZ(0)) dut1 (
    .clk(clk), .reset(reset), .value(val1), .load(ld1), .busy(busy1), .done(done1),
    .overflow(ovf1), .seg(seg1), .digit_en(en1)
  );
  bcd_display_driver #(.WIDTH(16), .DIGITS(5), .SCAN_DIV(4), .BLANK_LZ(1)) dut2 (
    .clk(clk), .reset(reset), .value(val2), .load(ld2), .busy(busy2), .done(done2),
    .overflow(ovf2), .seg(seg2), .digit_en(en2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] en_of(input int d);
    case (d)
      0:       return {5'd0, en0};
      1:       return {6'd0, en1};
      default: return {3'd0, en2};
    endcase
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0:       return seg0;
      1:       return seg1;
      default: return seg2;
    endcase
  endfunction

  function automatic logic done_of(input int d);
    case (d)
      0:       return done0;
      1:       return done1;
      default: return done2;
    endcase
  endfunction

  // Returns at the negedge after the load edge.
  task automatic start(input int d, input logic [15:0] v);
    @(negedge clk);
    case (d)
      0:       begin val0 = v[7:0]; ld0 = 1'b1; end
      1:       begin val1 = v[7:0]; ld1 = 1'b1; end
      default: begin val2 = v;      ld2 = 1'b1; end
    endcase
    @(negedge clk);
    ld0 = 1'b0; ld1 = 1'b0; ld2 = 1'b0;
  endtask

  task automatic wait_done(input int d, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!done_of(d) && cycles < 60);
  endtask

  task automatic scan_chk(input int d, input int idx, input logic [6:0] exp, input string tag);
    int n = 0;
    while (en_of(d) != (8'd1 << idx) && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_en"}, en_of(d), 8'd1 << idx);
    chk(tag, seg_of(d), exp);
  endtask

  initial begin
    reset = 1'b0;
    val0 = '0; val1 = '0; val2 = '0;
    ld0 = 1'b0; ld1 = 1'b0; ld2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_en", en0, 3'b001);
    chk("rst_seg", seg0, S0);
    reset = 1'b1;
    @(negedge clk);

    // 255 on three digits
    start(0, 16'd255);
    chk("busy_255", busy0, 1);
    wait_done(0, cyc);
    chk("lat_255", cyc, 9);
    @(negedge clk);
    chk("idle_255", busy0, 0);
    chk("done_pulse_255", done0, 0);
    chk("ovf_255", ovf0, 0);
    repeat (12) @(negedge clk);
    scan_chk(0, 0, S5, "d255_0");
    scan_chk(0, 1, S5, "d255_1");
    scan_chk(0, 2, S2, "d255_2");

    // 100 on two digits overflows
    start(1, 16'd100);
    wait_done(1, cyc);
    chk("lat_100", cyc, 9);
    chk("ovf_100", ovf1, 1);
    repeat (8) @(negedge clk);
    scan_chk(1, 0, SD, "d100_0");
    scan_chk(1, 1, SD, "d100_1");

    // 5 on two digits without blanking shows 05
    start(1, 16'd5);
    wait_done(1, cyc);
    chk("ovf_5", ovf1, 0);
    repeat (8) @(negedge clk);
    scan_chk(1, 0, S5, "d5_0");
    scan_chk(1, 1, S0, "d5_1");

    // 7 with blanking: slot timing and content
    start(0, 16'd7);
    wait_done(0, cyc);
    repeat (12) @(negedge clk);
    scan_chk(0, 2, SB, "d7_pre");
    scan_chk(0, 0, S7, "d7_start");
    for (int k = 1; k < 12; k++) begin
      @(negedge clk);
      chk("d7_seq_en", en0, 3'b001 << ((k / 4) % 3));
      chk("d7_seq_seg", seg0, ((k / 4) % 3 == 0) ? S7 : SB);
    end

    // 42 with loads on cycle 3 (shifting) and cycle 9 (commit), both ignored
    start(0, 16'd42);
    repeat (2) @(negedge clk);
    val0 = 8'd99; ld0 = 1'b1;
    @(negedge clk);
    ld0 = 1'b0;
    repeat (5) @(negedge clk);
    ld0 = 1'b1;
    @(negedge clk);
    ld0 = 1'b0;
    chk("done_42", done0, 1);
    @(negedge clk);
    chk("commit_load_ignored", busy0, 0);
    ndone = 0;
    repeat (14) begin
      @(negedge clk);
      if (done0) ndone++;
    end
    chk("no_extra_done_42", ndone, 0);
    scan_chk(0, 0, S2, "d42_0");
    scan_chk(0, 1, S4, "d42_1");
    scan_chk(0, 2, SB, "d42_2");

    // reset during shift abandons the conversion
    start(0, 16'd123);
    repeat (4) @(negedge clk);
    chk("busy_before_rst", busy0, 1);
    reset = 1'b0;
    #1;
    chk("midrst_busy", busy0, 0);
    chk("midrst_en", en0, 3'b001);
    chk("midrst_seg", seg0, S0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done0) ndone++;
    end
    chk("no_done_after_rst", ndone, 0);
    scan_chk(0, 0, S0, "drst_0");
    scan_chk(0, 1, SB, "drst_1");
    scan_chk(0, 2, SB, "drst_2");
    start(0, 16'd123);
    wait_done(0, cyc);
    chk("lat_123", cyc, 9);
    repeat (12) @(negedge clk);
    scan_chk(0, 0, S3, "d123_0");
    scan_chk(0, 1, S2, "d123_1");
    scan_chk(0, 2, S1, "d123_2");

    // 65535 on a 16-bit, five-digit instance
    start(2, 16'd65535);
    wait_done(2, cyc);
    chk("lat_65535", cyc, 17);
    chk("ovf_65535", ovf2, 0);
    repeat (20) @(negedge clk);
    scan_chk(2, 0, S5, "d65535_0");
    scan_chk(2, 1, S3, "d65535_1");
    scan_chk(2, 2, S5, "d65535_2");
    scan_chk(2, 3, S5, "d65535_3");
    scan_chk(2, 4, S6, "d65535_4");

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/bcd_display_driver.md
BCD_DISPLAY_DRIVER -- requirements
Module: bcd_display_driver

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: binary input width, 4..20.
REQ-002 The block SHALL have parameter DIGITS, default 3: number of displayed decimal digits, 1..7.
REQ-003 The block SHALL have parameter SCAN_DIV, default 1000: clk cycles per digit slot, >=2.
REQ-004 The block SHALL have parameter BLANK_LZ, default 1: blank leading zeros when 1.
REQ-005 The block SHALL have port clk, input, 1: sole clock, rising edge.
REQ-006 The block SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 The block SHALL have port value, input, WIDTH: unsigned binary to display.
REQ-008 The block SHALL have port load, input, 1: single-cycle start request.
REQ-009 The block SHALL have port busy, output, 1: conversion in progress.
REQ-010 The block SHALL have port done, output, 1: one-cycle pulse when the display register is updated.
REQ-011 The block SHALL have port overflow, output, 1: last converted value >= 10^DIGITS.
REQ-012 The block SHALL have port seg, output, 7: active-high {g,f,e,d,c,b,a} pattern of the selected digit.
REQ-013 The block SHALL have port digit_en, output, DIGITS: one-hot active-high digit select; bit 0 = ones.

Function
REQ-014 The FSM SHALL have states IDLE, SHIFT and COMMIT.
REQ-015 In IDLE with load=1, the block SHALL capture value, clear the BCD accumulator, load the shift counter with WIDTH and enter SHIFT.
REQ-016 In SHIFT, each cycle SHALL add 3 to every accumulator nibble >=5, then shift {accumulator,binary} left by 1 and decrement the counter.
REQ-017 When the counter reaches 0, the FSM SHALL enter COMMIT.
REQ-018 The accumulator SHALL hold NACC = ceil(WIDTH*log10(2)) nibbles, so no bits are lost.
REQ-019 COMMIT SHALL copy the low DIGITS nibbles to the display register, set overflow when any nibble at or above index DIGITS is nonzero, pulse done for one cycle and return to IDLE.
REQ-020 Latency SHALL be exactly WIDTH+1 cycles from the load edge to the done edge.
REQ-021 busy SHALL be 1 in SHIFT and COMMIT and 0 in IDLE.
REQ-022 load while busy=1 SHALL be ignored, neither queued nor restarting conversion.
REQ-023 load in the same cycle as COMMIT SHALL also be ignored.
REQ-024 The display register and overflow SHALL hold their values between conversions.
REQ-025 The scan counter SHALL count 0..SCAN_DIV-1 continuously and independently of the FSM.
REQ-026 On wrap of the scan counter, the digit index SHALL advance and wrap from DIGITS-1 to 0.
REQ-027 digit_en SHALL be the one-hot decode of the digit index, exactly one bit high at all times.
REQ-028 When overflow=1, seg SHALL be 7'b1000000 (dash) on every digit.
REQ-029 When BLANK_LZ=1, each zero digit above the highest nonzero digit SHALL output seg=0; digit 0 SHALL never be blanked.
REQ-030 Otherwise, seg SHALL be the decimal 0-9 decode of the selected nibble.
REQ-031 seg and digit_en SHALL be registered and change together on the same edge as the digit index.
REQ-032 A display-register update mid-slot SHALL take effect on the next digit-index change.

Reset
REQ-033 While reset=0, the FSM SHALL be IDLE, with busy=0, done=0 and overflow=0.
REQ-034 While reset=0, the display register and accumulator SHALL be 0, the scan counter and digit index 0, digit_en=1 and seg=7'b0111111 ("0").
REQ-035 Reset asserted during SHIFT SHALL abandon the conversion with no done pulse, leaving the display at 0.
REQ-036 Reset release SHALL be synchronised externally; outputs SHALL be valid from the first clk edge after release.

Structure
REQ-037 A shared package SHALL hold the segment patterns for 0-9, the dash and blank constants, the state encoding and a constant function computing NACC.
REQ-038 The 7-segment decode SHALL be the team's existing seven_segment sub-module, instantiated once on the selected-digit path.
REQ-039 Double-dabble, blanking, overflow and scan logic SHALL reside in this module.

Verification
REQ-040 With WIDTH=8, DIGITS=3, load value=8'd255: done SHALL pulse 9 cycles later, display register = 2,5,5, overflow=0.
REQ-041 With WIDTH=8, DIGITS=2, load 8'd100: overflow=1 and every digit slot SHALL show seg=7'b1000000.
REQ-042 Load 8'd7 with BLANK_LZ=1, SCAN_DIV=4: digit_en SHALL cycle 001->010->100 every 4 cycles, with seg 7'b0000111, 0, 0.
REQ-043 Load 8'd42, then pulse load with 8'd99 on cycle 3: the second request SHALL be ignored and the display SHALL read 042 (blanked: 42).
REQ-044 Assert reset in cycle 4 of SHIFT: there SHALL be no done pulse, the display SHALL read 0, and the next load SHALL convert normally.
REQ-045 WIDTH=16, DIGITS=5, load 16'd65535: latency SHALL be 17 cycles and digits SHALL read 6,5,5,3,5, overflow=0.
